// File: rtl/multu_hilo_pkg.sv
// Shared CPU definitions: R-type funct codes (common to the EX result select
// and the HI/LO unit) and the multiplier FSM state encoding.
package multu_hilo_pkg;

  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/multu_hilo_shift_add_step.sv
// One radix-2 shift-add iteration: conditionally add the multiplicand into the
// accumulator, then shift {carry,sum,mplr} right by one. The carry out of the
// add lands in the accumulator MSB, so no product bit is ever lost.
module shift_add_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplr,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] mplr_nxt
);

  logic [WIDTH:0] sum;

  // add-then-shift datapath for a single multiplier bit
  always_comb begin
    sum = {1'b0, acc} + (mplr[0] ? {1'b0, mcand} : '0);
    {acc_nxt, mplr_nxt} = {sum, mplr[WIDTH-1:1]};
  end

endmodule

// File: rtl/multu_hilo.sv
// Multi-cycle unsigned multiplier with HI/LO register pair (EX stage).
// Optional MTHI/MTLO writes are enabled by defining HILO_MTHI_MTLO_EN.
module multu_hilo
  import multu_hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc, mcand, mplr, hi, lo;
  logic [WIDTH-1:0] acc_nxt, mplr_nxt;
  logic             accept, last;

  assign accept = (state == ST_IDLE) && start && (funct == F_MULTU);
  assign last   = (state == ST_RUN) && (count == CW'(WIDTH - 1));

  // busy comes straight off the state flop; HI/LO are plain register outputs
  assign busy   = (state == ST_RUN);
  assign hi_out = hi;
  assign lo_out = lo;

  shift_add_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .mcand    (mcand),
    .mplr     (mplr),
    .acc_nxt  (acc_nxt),
    .mplr_nxt (mplr_nxt)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // next-state: accept a MULTU in IDLE, return after the WIDTH-th iteration
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_RUN;
      ST_RUN:  if (last)   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // datapath, iteration counter, HI/LO and the done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
      count <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE) begin
        if (accept) begin
          acc   <= '0;
          mcand <= op_a;
          mplr  <= op_b;
          count <= '0;
        end
`ifdef HILO_MTHI_MTLO_EN
        else if (start && funct == F_MTHI) hi <= op_a;
        else if (start && funct == F_MTLO) lo <= op_a;
`endif
      end else begin
        acc  <= acc_nxt;
        mplr <= mplr_nxt;
        if (last) begin
          // counter parks at zero so it never wraps
          count <= '0;
          hi    <= acc_nxt;
          lo    <= mplr_nxt;
          done  <= 1'b1;
        end else begin
          count <= count + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_multu_hilo.sv
// Directed self-checking bench for multu_hilo (WIDTH=32).
module tb_multu_hilo;
  import multu_hilo_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [5:0]   funct;
  logic [W-1:0] op_a, op_b;
  logic         busy, done;
  logic [W-1:0] hi_out, lo_out;

  int tests = 0;
  int fails = 0;

  multu_hilo #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct  (funct),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .hi_out (hi_out),
    .lo_out (lo_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // present one instruction for a single edge
  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; funct = f; op_a = a; op_b = b;
    step();
    start = 1'b0; funct = F_ADD;
  endtask

  // n0 = edges already taken since the accept edge; checks busy length,
  // one-cycle done pulse and the final HI/LO
  task automatic finish_mul(input string tag, input int n0,
                            input logic [W-1:0] ehi, input logic [W-1:0] elo);
    int n = n0;
    while (busy && n < 100) begin
      n++;
      step();
    end
    chk({tag, " busy_cycles"}, 64'(n), 64'd32);
    chk({tag, " done_hi"}, 64'(done), 64'd1);
    chk({tag, " hi"}, 64'(hi_out), 64'(ehi));
    chk({tag, " lo"}, 64'(lo_out), 64'(elo));
    step();
    chk({tag, " done_lo"}, 64'(done), 64'd0);
  endtask

  initial begin
    int ndone;
    rst = 1'b1; start = 1'b0; funct = F_ADD; op_a = '0; op_b = '0;
    step(); step();
    rst = 1'b0;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst hi", 64'(hi_out), 64'd0);
    chk("rst lo", 64'(lo_out), 64'd0);

    // 3 x 5 = 15
    issue(F_MULTU, 32'd3, 32'd5);
    chk("3x5 busy_start", 64'(busy), 64'd1);
    chk("3x5 hold_hi", 64'(hi_out), 64'd0);
    finish_mul("3x5", 0, 32'h0, 32'h0000_000F);

    // all-ones squared exercises the carry into the accumulator MSB
    issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step(); step();
    chk("ff hold_lo", 64'(lo_out), 64'h0F);
    finish_mul("ffxff", 2, 32'hFFFF_FFFE, 32'h0000_0001);

    // second MULTU while busy is dropped: 0x10000^2 = 1:0
    issue(F_MULTU, 32'h0001_0000, 32'h0001_0000);
    repeat (4) step();
    issue(F_MULTU, 32'd7, 32'd9);
    finish_mul("b2b", 5, 32'h1, 32'h0);
    issue(F_MULTU, 32'd7, 32'd9);
    finish_mul("7x9", 0, 32'h0, 32'h3F);

    // non-multiply functs leave everything alone
    issue(F_MFHI, 32'hAAAA_AAAA, 32'h5555_5555);
    issue(F_SRL,  32'hAAAA_AAAA, 32'h5555_5555);
    chk("nop busy", 64'(busy), 64'd0);
    chk("nop lo", 64'(lo_out), 64'h3F);

    // abort mid-run at busy cycle 10
    issue(F_MULTU, 32'h1234, 32'h10);
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort hi", 64'(hi_out), 64'd0);
    chk("abort lo", 64'(lo_out), 64'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) ndone++;
      step();
    end
    chk("abort no_done", 64'(ndone), 64'd0);

`ifdef HILO_MTHI_MTLO_EN
    issue(F_MTHI, 32'hDEAD_BEEF, 32'h0);
    chk("mthi hi", 64'(hi_out), 64'hDEAD_BEEF);
    chk("mthi busy", 64'(busy), 64'd0);
    issue(F_MTLO, 32'h1234_5678, 32'h0);
    chk("mtlo lo", 64'(lo_out), 64'h1234_5678);
    chk("mtlo done", 64'(done), 64'd0);
    issue(F_MULTU, 32'd2, 32'd3);
    step(); step();
    issue(F_MTHI, 32'h1, 32'h0);
    chk("mthi busy hi", 64'(hi_out), 64'hDEAD_BEEF);
    issue(F_MTLO, 32'h2, 32'h0);
    chk("mtlo busy lo", 64'(lo_out), 64'h1234_5678);
    finish_mul("2x3", 4, 32'h0, 32'h6);
`else
    issue(F_MTHI, 32'hDEAD_BEEF, 32'h0);
    issue(F_MTLO, 32'h1234_5678, 32'h0);
    chk("mthi nop hi", 64'(hi_out), 64'h0);
    chk("mtlo nop lo", 64'(lo_out), 64'h0);
    chk("mt nop busy", 64'(busy), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
